// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage datapath and the alu.
// Latency: none (wires only); the alu registers its outputs one cycle after sampling.
// Backpressure: none; the datapath may present a new operation every cycle.
//
// Signals:
//   a, b     operands (a[4:0] is the shift amount, b is the shifted value)
//   ALUOp    6-bit funct-style operation select
//   out      registered result
//   zero     registered (out == 0)
//   overflow registered signed-overflow flag, only when ALU_OVERFLOW_EN is defined
// Modports: master = datapath (drives operands), slave = alu (drives results).
interface alu_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  ALUOp;
    logic [31:0] out;
    logic        zero;
`ifdef ALU_OVERFLOW_EN
    logic        overflow;

    modport master (output a, b, ALUOp, input out, zero, overflow);
    modport slave  (input a, b, ALUOp, output out, zero, overflow);
`else
    modport master (output a, b, ALUOp, input out, zero);
    modport slave  (input a, b, ALUOp, output out, zero);
`endif
endinterface

// File: rtl/alu.sv
// 32-bit execute-stage ALU, funct-style opcodes, result and zero flag registered.
// Latency: 1 cycle from operand sampling to out/zero/overflow; throughput 1 op/cycle.
// Backpressure: none; every rising clk accepts the current operands.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset (out = 0, zero = 1, overflow = 0)
//   bus  alu_if.slave: a, b, ALUOp in; out, zero (and overflow) out
// Optional feature: define ALU_OVERFLOW_EN to build the registered signed-overflow flag.
module alu (
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    localparam logic [5:0] OP_SLL  = 6'h00;
    localparam logic [5:0] OP_SRL  = 6'h02;
    localparam logic [5:0] OP_SRA  = 6'h03;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_ADDU = 6'h21;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_SUBU = 6'h23;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    localparam logic [5:0] OP_SLTU = 6'h2B;

    logic [31:0] sum;
    logic [31:0] diff;
    logic [4:0]  shamt;
    logic [31:0] result;

    assign sum   = bus.a + bus.b;
    assign diff  = bus.a - bus.b;
    // Only the low five bits of a select the shift distance.
    assign shamt = bus.a[4:0];

    always_comb begin
        result = 32'h0;
        unique case (bus.ALUOp)
            OP_SLL:            result = bus.b << shamt;
            OP_SRL:            result = bus.b >> shamt;
            OP_SRA:            result = $unsigned($signed(bus.b) >>> shamt);
            OP_LUI:            result = {bus.b[15:0], 16'h0000};
            OP_ADD, OP_ADDU:   result = sum;
            OP_SUB, OP_SUBU:   result = diff;
            OP_AND:            result = bus.a & bus.b;
            OP_OR:             result = bus.a | bus.b;
            OP_XOR:            result = bus.a ^ bus.b;
            OP_NOR:            result = ~(bus.a | bus.b);
            OP_SLT:            result = {31'h0, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU:           result = {31'h0, bus.a < bus.b};
            default:           result = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out  <= 32'h0;
            bus.zero <= 1'b1;
        end else begin
            bus.out  <= result;
            bus.zero <= (result == 32'h0);
        end
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf;

    // Signed overflow only for the trapping-style ADD/SUB codes; the wrapped
    // result is still written, the flag just reports it.
    always_comb begin
        ovf = 1'b0;
        if (bus.ALUOp == OP_ADD)
            ovf = (bus.a[31] == bus.b[31]) && (sum[31] != bus.a[31]);
        else if (bus.ALUOp == OP_SUB)
            ovf = (bus.a[31] != bus.b[31]) && (diff[31] != bus.a[31]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            bus.overflow <= 1'b0;
        else
            bus.overflow <= ovf;
    end
`endif

endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: reset behaviour, every opcode, flags and
// one-cycle latency with a new operation every cycle.
module tb_alu;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  op;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out"}, bus.out, 32'h0);
        check({tag, "_zero"}, {31'h0, bus.zero}, 32'h1);
`ifdef ALU_OVERFLOW_EN
        check({tag, "_ovf"}, {31'h0, bus.overflow}, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] prev;
        checks = 0;
        errors = 0;

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 6'h20, 32'h80000000, 1'b1};
        vecs[1]  = '{32'h7FFFFFFF, 32'h00000001, 6'h21, 32'h80000000, 1'b0};
        vecs[2]  = '{32'h00001234, 32'h00001234, 6'h22, 32'h00000000, 1'b0};
        vecs[3]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 6'h27, 32'h00000000, 1'b0};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 6'h2A, 32'h00000001, 1'b0};
        vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 6'h2B, 32'h00000000, 1'b0};
        vecs[6]  = '{32'h00000024, 32'h80000010, 6'h00, 32'h00000100, 1'b0};
        vecs[7]  = '{32'h00000024, 32'h80000010, 6'h02, 32'h08000001, 1'b0};
        vecs[8]  = '{32'h00000024, 32'h80000010, 6'h03, 32'hF8000001, 1'b0};
        vecs[9]  = '{32'h00000024, 32'hABCD1234, 6'h0F, 32'h12340000, 1'b0};
        vecs[10] = '{32'h00000005, 32'h00000007, 6'h3F, 32'h00000000, 1'b0};
        vecs[11] = '{32'h80000000, 32'h00000001, 6'h22, 32'h7FFFFFFF, 1'b1};
        vecs[12] = '{32'h80000000, 32'h00000001, 6'h23, 32'h7FFFFFFF, 1'b0};
        vecs[13] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h24, 32'hF000F000, 1'b0};
        vecs[14] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h25, 32'hFFF0FFF0, 1'b0};
        vecs[15] = '{32'hF0F0F0F0, 32'hFF00FF00, 6'h26, 32'h0FF00FF0, 1'b0};
        vecs[16] = '{32'h00000005, 32'h00000007, 6'h20, 32'h0000000C, 1'b0};
        vecs[17] = '{32'h80000000, 32'h80000000, 6'h20, 32'h00000000, 1'b1};
        vecs[18] = '{32'h00000001, 32'hFFFFFFFF, 6'h2A, 32'h00000000, 1'b0};
        vecs[19] = '{32'h00000001, 32'hFFFFFFFF, 6'h2B, 32'h00000001, 1'b0};

        // Asynchronous reset asserted between edges with an ADD pending on the inputs.
        rst       = 1'b0;
        bus.a     = 32'd5;
        bus.b     = 32'd7;
        bus.ALUOp = 6'h20;
        #2 rst = 1'b1;
        #1 check_reset_state("rst_async");
        repeat (2) @(posedge clk);
        #1 check_reset_state("rst_held");

        // Deassert: the next edge loads 5 + 7.
        @(negedge clk) rst = 1'b0;
        #1 check("rst_rel_pre", bus.out, 32'h0);
        @(posedge clk);
        #1 check("rst_rel_out", bus.out, 32'h0000000C);
        check("rst_rel_zero", {31'h0, bus.zero}, 32'h0);
        prev = 32'h0000000C;

        // Back-to-back vectors: new inputs every negedge, result one edge later.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            bus.a     = vecs[i].a;
            bus.b     = vecs[i].b;
            bus.ALUOp = vecs[i].op;
            #1 check($sformatf("v%0d_hold", i), bus.out, prev);
            @(posedge clk);
            #1 check($sformatf("v%0d_out", i), bus.out, vecs[i].res);
            check($sformatf("v%0d_zero", i), {31'h0, bus.zero},
                  {31'h0, (vecs[i].res == 32'h0)});
`ifdef ALU_OVERFLOW_EN
            check($sformatf("v%0d_ovf", i), {31'h0, bus.overflow}, {31'h0, vecs[i].ovf});
`endif
            prev = vecs[i].res;
        end

        // Reset mid-stream discards the pending ADD-overflow result.
        @(negedge clk);
        bus.a     = 32'h7FFFFFFF;
        bus.b     = 32'h00000001;
        bus.ALUOp = 6'h20;
        @(posedge clk);
        #1 check("mid_out", bus.out, 32'h80000000);
        #2 rst = 1'b1;
        #1 check_reset_state("mid_rst");
        @(posedge clk);
        #1 check_reset_state("mid_rst_edge");
        @(negedge clk) rst = 1'b0;
        bus.ALUOp = 6'h25;
        @(posedge clk);
        #1 check("mid_rel_out", bus.out, 32'h7FFFFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
